// File: rtl/screen_write_arbiter_pkg.sv
// Shared screen geometry, fill character and arbiter state encoding for the
// character-screen write path (UART writer, arbiter, VGA text renderer).
package screen_write_arbiter_pkg;

  localparam int DEFAULT_SCREEN_ADDRESS_WIDTH  = 13;
  localparam int DEFAULT_HORIZONTAL_SLOT_COUNT = 80;
  localparam int DEFAULT_VERTICAL_SLOT_COUNT   = 60;
  localparam int DEFAULT_ROW_WIDTH             = 6;

  localparam logic [6:0] DEFAULT_CLEAR_CHAR = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP_SCREEN,
    SWEEP_ROW
  } arb_state_e;

endpackage

// File: rtl/screen_write_arbiter_sweep_counter.sv
// Address generator for a clear sweep: base + running offset, flagging the
// final address of a sweep of length len_i (len_i must be non-zero).
module sweep_counter
  import screen_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_SCREEN_ADDRESS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] lastIdx_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  // A start always wins over counting so back-to-back sweeps reload cleanly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q    <= '0;
      lastIdx_q <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      base_q    <= base_i;
      lastIdx_q <= len_i - ADDR_WIDTH'(1);
      cnt_q     <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
    end
  end

  assign addr_o = base_q + cnt_q;
  assign last_o = (cnt_q == lastIdx_q);

endmodule

// File: rtl/screen_write_arbiter.sv
// Owns the character-screen BRAM write port, sharing it between the UART
// writer (valid/ready) and the screen/row clear engine.
module screen_write_arbiter
  import screen_write_arbiter_pkg::*;
#(
  parameter int         SCREEN_ADDRESS_WIDTH  = DEFAULT_SCREEN_ADDRESS_WIDTH,
  parameter int         HORIZONTAL_SLOT_COUNT = DEFAULT_HORIZONTAL_SLOT_COUNT,
  parameter int         VERTICAL_SLOT_COUNT   = DEFAULT_VERTICAL_SLOT_COUNT,
  parameter logic [6:0] CLEAR_CHAR            = DEFAULT_CLEAR_CHAR,
  parameter int         ROW_WIDTH             = DEFAULT_ROW_WIDTH
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [SCREEN_ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [6:0]                      wr_data,
  input  logic                            clr_screen_req,
  input  logic                            clr_row_req,
  input  logic [ROW_WIDTH-1:0]            clr_row,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            bram_wen,
  output logic [SCREEN_ADDRESS_WIDTH-1:0] bram_addr,
  output logic [6:0]                      bram_data
);

  localparam int AW = SCREEN_ADDRESS_WIDTH;
  localparam logic [AW-1:0]        ROW_LEN    = AW'(HORIZONTAL_SLOT_COUNT);
  localparam logic [AW-1:0]        SCREEN_LEN = AW'(HORIZONTAL_SLOT_COUNT * VERTICAL_SLOT_COUNT);
  localparam logic [ROW_WIDTH:0]   ROW_LIMIT  = (ROW_WIDTH + 1)'(VERTICAL_SLOT_COUNT);

  arb_state_e           state_q, state_d;
  logic                 screenPend_q, screenPend_d;
  logic                 rowPend_q, rowPend_d;
  logic [ROW_WIDTH-1:0] rowIdx_q, rowIdx_d;

  logic                 wrWen_q;
  logic [AW-1:0]        wrAddr_q;
  logic [6:0]           wrData_q;
  logic                 clrDone_q;

  logic                 sweeping;
  logic                 sweepStart;
  logic [AW-1:0]        sweepBase;
  logic [AW-1:0]        sweepLen;
  logic [AW-1:0]        sweepAddr;
  logic                 sweepLast;
  logic                 rowValid;
  logic                 wrAccept;

  assign sweeping = (state_q != IDLE);
  assign rowValid = ({1'b0, clr_row} < ROW_LIMIT);
  assign wr_ready = (state_q == IDLE) & ~screenPend_q & ~rowPend_q
                  & ~clr_screen_req & ~clr_row_req & resetn;
  assign wrAccept = wr_valid & wr_ready;

  sweep_counter #(
    .ADDR_WIDTH (AW)
  ) u_sweep_counter (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .start_i (sweepStart),
    .en_i    (sweeping),
    .base_i  (sweepBase),
    .len_i   (sweepLen),
    .addr_o  (sweepAddr),
    .last_o  (sweepLast)
  );

  // Requests seen during a sweep are folded into the pending flags first, so
  // the end-of-sweep selection treats same-cycle requests exactly like older ones.
  always_comb begin
    state_d      = state_q;
    screenPend_d = screenPend_q;
    rowPend_d    = rowPend_q;
    rowIdx_d     = rowIdx_q;
    sweepStart   = 1'b0;
    sweepBase    = '0;
    sweepLen     = '0;

    if (sweeping) begin
      if (clr_screen_req) screenPend_d = 1'b1;
      if (clr_row_req && rowValid && (state_q == SWEEP_ROW) && !screenPend_d) begin
        rowPend_d = 1'b1;
        rowIdx_d  = clr_row;
      end
    end

    if (state_q == IDLE) begin
      if (clr_screen_req) begin
        state_d    = SWEEP_SCREEN;
        sweepStart = 1'b1;
        sweepLen   = SCREEN_LEN;
      end else if (clr_row_req && rowValid) begin
        state_d    = SWEEP_ROW;
        sweepStart = 1'b1;
        sweepBase  = AW'(clr_row) * ROW_LEN;
        sweepLen   = ROW_LEN;
      end
    end else if (sweepLast) begin
      if (screenPend_d) begin
        state_d      = SWEEP_SCREEN;
        sweepStart   = 1'b1;
        sweepLen     = SCREEN_LEN;
        screenPend_d = 1'b0;
        rowPend_d    = 1'b0;
      end else if (rowPend_d) begin
        state_d    = SWEEP_ROW;
        sweepStart = 1'b1;
        sweepBase  = AW'(rowIdx_d) * ROW_LEN;
        sweepLen   = ROW_LEN;
        rowPend_d  = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      screenPend_q <= 1'b0;
      rowPend_q    <= 1'b0;
      rowIdx_q     <= '0;
      clrDone_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      screenPend_q <= screenPend_d;
      rowPend_q    <= rowPend_d;
      rowIdx_q     <= rowIdx_d;
      clrDone_q    <= sweeping & sweepLast;
    end
  end

  // Writer output register; a write is only ever accepted in IDLE with no
  // request present, so it can never collide with a sweep write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrWen_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      wrWen_q <= wrAccept;
      if (wrAccept) begin
        wrAddr_q <= wr_addr;
        wrData_q <= wr_data;
      end
    end
  end

  assign bram_wen  = sweeping | wrWen_q;
  assign bram_addr = sweeping ? sweepAddr : wrAddr_q;
  assign bram_data = sweeping ? CLEAR_CHAR : wrData_q;
  assign clr_busy  = sweeping | screenPend_q | rowPend_q;
  assign clr_done  = clrDone_q;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Directed and randomized checks of screen_write_arbiter against a cycle-level
// reference model built from the sweep/priority rules.
module tb_screen_write_arbiter;

  localparam int H = 80;
  localparam int V = 60;

  logic        clk, resetn;
  logic        wrValid, wrReady;
  logic [12:0] wrAddr;
  logic [6:0]  wrData;
  logic        clrScreenReq, clrRowReq;
  logic [5:0]  clrRow;
  logic        clrBusy, clrDone, bramWen;
  logic [12:0] bramAddr;
  logic [6:0]  bramData;

  int vectorCount = 0;
  int missCount   = 0;
  int doneSeen, sweepWrites, rangeHits, rangeLo, rangeHi, guard, kind;

  // Reference model state: what the BRAM port should show in the current cycle.
  bit mSweeping, mIsRow, mPendScreen, mPendRow, mWrLand, mDone;
  int mAddr, mEnd, mPendRowIdx, mWrAddr, mWrData;

  screen_write_arbiter dut (
    .clk            (clk),
    .resetn         (resetn),
    .wr_valid       (wrValid),
    .wr_ready       (wrReady),
    .wr_addr        (wrAddr),
    .wr_data        (wrData),
    .clr_screen_req (clrScreenReq),
    .clr_row_req    (clrRowReq),
    .clr_row        (clrRow),
    .clr_busy       (clrBusy),
    .clr_done       (clrDone),
    .bram_wen       (bramWen),
    .bram_addr      (bramAddr),
    .bram_data      (bramData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void modelReset();
    mSweeping = 0; mIsRow = 0; mPendScreen = 0; mPendRow = 0;
    mWrLand = 0; mDone = 0; mAddr = 0; mEnd = 0; mPendRowIdx = 0;
    mWrAddr = 0; mWrData = 0;
  endfunction

  function automatic void startSweep(bit isRow, int row);
    mSweeping = 1;
    mIsRow    = isRow;
    mAddr     = isRow ? row * H : 0;
    mEnd      = isRow ? mAddr + H : H * V;
  endfunction

  function automatic bit modelReady();
    return !mSweeping && !mPendScreen && !mPendRow && !clrScreenReq && !clrRowReq && resetn;
  endfunction

  function automatic logic [23:0] expectedVector();
    logic        wen;
    logic [12:0] a;
    logic [6:0]  d;
    wen = mSweeping || mWrLand;
    a   = mSweeping ? 13'(mAddr) : 13'(mWrAddr);
    d   = mSweeping ? 7'h20 : 7'(mWrData);
    if (!wen) begin
      a = '0;
      d = '0;
    end
    return {wen, a, d, mSweeping || mPendScreen || mPendRow, mDone, modelReady()};
  endfunction

  // Advance the model across one clock edge using this cycle's inputs.
  function automatic void modelAdvance();
    bit land;
    int row;
    if (!resetn) begin
      modelReset();
      return;
    end
    land = wrValid && modelReady();
    row  = int'(clrRow);
    if (mSweeping) begin
      if (clrScreenReq) mPendScreen = 1;
      if (clrRowReq && row < V && mIsRow && !mPendScreen) begin
        mPendRow    = 1;
        mPendRowIdx = row;
      end
      if (mAddr == mEnd - 1) begin
        mDone = 1;
        if (mPendScreen) begin
          mPendScreen = 0;
          mPendRow    = 0;
          startSweep(0, 0);
        end else if (mPendRow) begin
          mPendRow = 0;
          startSweep(1, mPendRowIdx);
        end else begin
          mSweeping = 0;
        end
      end else begin
        mAddr++;
        mDone = 0;
      end
    end else begin
      mDone = 0;
      if (clrScreenReq) startSweep(0, 0);
      else if (clrRowReq && row < V) startSweep(1, row);
    end
    mWrLand = land;
    if (land) begin
      mWrAddr = int'(wrAddr);
      mWrData = int'(wrData);
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [12:0] a, input logic [6:0] d,
                               input logic s, input logic r, input logic [5:0] ri);
    wrValid      = v;
    wrAddr       = a;
    wrData       = d;
    clrScreenReq = s;
    clrRowReq    = r;
    clrRow       = ri;
  endtask

  task automatic checkOutput(input string tag);
    logic [23:0] expv, obsv;
    expv = expectedVector();
    obsv = {bramWen, bramWen ? bramAddr : 13'd0, bramWen ? bramData : 7'd0,
            clrBusy, clrDone, wrReady};
    if (clrDone === 1'b1) doneSeen++;
    if (bramWen === 1'b1 && bramData === 7'h20) begin
      sweepWrites++;
      if (int'(bramAddr) >= rangeLo && int'(bramAddr) <= rangeHi) rangeHits++;
    end
    vectorCount++;
    assert (obsv === expv) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obsv, expv);
    end
  endtask

  task automatic checkDirect(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    vectorCount++;
    assert (obsv === expv) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obsv, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    checkDirect(tag, {8'd0, bramWen, bramAddr, bramData, clrBusy, clrDone, wrReady}, 32'd0);
  endtask

  // Entered and left at posedge+1; outputs are sampled at posedge+2.
  task automatic runCycle(input string tag);
    #1;
    checkOutput(tag);
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounters(input int lo, input int hi);
    doneSeen = 0; sweepWrites = 0; rangeHits = 0; rangeLo = lo; rangeHi = hi;
  endtask

  task automatic runQuiet(input string tag, input bit randomWriter);
    guard = 0;
    while ((mSweeping || mPendScreen || mPendRow) && guard < 20000) begin
      if (randomWriter)
        applyStimulus(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                      7'($urandom_range(0, 127)), 1'b0, 1'b0, 6'd0);
      else
        applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
      runCycle(tag);
      guard++;
    end
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    repeat (3) runCycle(tag);
  endtask

  initial begin
    modelReset();
    clearCounters(0, -1);
    resetn = 1'b0;
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    @(posedge clk);
    #1;
    checkReset("reset_state");
    runCycle("reset_model");
    resetn = 1'b1;

    // Single writer transfer, then an asynchronous reset while it is on the port.
    applyStimulus(1'b1, 13'd5, 7'h41, 1'b0, 1'b0, 6'd0);
    runCycle("wr_accept");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checkOutput("wr_land");
    checkDirect("wr_land_direct", {11'd0, bramWen, bramAddr, bramData}, {11'd0, 1'b1, 13'd5, 7'h41});
    resetn = 1'b0;
    #1;
    checkReset("reset_mid_write");
    modelReset();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                    7'($urandom_range(0, 127)), 1'b0, 1'b0, 6'd0);
      runCycle("writer_random");
    end

    // Full-screen clear with a writer held off for the whole sweep.
    clearCounters(0, 4799);
    applyStimulus(1'b1, 13'h123, 7'h55, 1'b1, 1'b0, 6'd0);
    runCycle("screen_req");
    applyStimulus(1'b1, 13'h123, 7'h55, 1'b0, 1'b0, 6'd0);
    guard = 0;
    while (mSweeping && guard < 6000) begin
      runCycle("screen_sweep");
      guard++;
    end
    runCycle("screen_done");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checkDirect("held_write_lands", {11'd0, bramWen, bramAddr, bramData}, {11'd0, 1'b1, 13'h123, 7'h55});
    checkDirect("screen_writes", sweepWrites, 4800);
    checkDirect("screen_done_count", doneSeen, 1);
    modelAdvance();
    @(posedge clk);
    #1;

    // Last row, then an out-of-range row that must be ignored.
    clearCounters(4720, 4799);
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd59);
    runCycle("row59_req");
    runQuiet("row59_sweep", 1'b0);
    checkDirect("row59_hits", rangeHits, 80);
    checkDirect("row59_done", doneSeen, 1);
    clearCounters(0, 8191);
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd60);
    runCycle("row60_req");
    runQuiet("row60_idle", 1'b0);
    checkDirect("row60_writes", sweepWrites, 0);
    checkDirect("row60_done", doneSeen, 0);

    // Row 3, then screen pending, then row 7 dropped because screen is pending.
    clearCounters(240, 319);
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd3);
    runCycle("row3_req");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    repeat (10) runCycle("row3_sweep");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b1, 1'b0, 6'd0);
    runCycle("screen_pend_req");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    repeat (5) runCycle("row3_sweep");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd7);
    runCycle("row7_req");
    runQuiet("row3_screen", 1'b0);
    checkDirect("row3_screen_writes", sweepWrites, 4880);
    checkDirect("row3_screen_done", doneSeen, 2);

    // Row 2, then row 4 overwritten by row 9.
    clearCounters(320, 399);
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd2);
    runCycle("row2_req");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    repeat (10) runCycle("row2_sweep");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd4);
    runCycle("row4_req");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    repeat (10) runCycle("row2_sweep");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b1, 6'd9);
    runCycle("row9_req");
    runQuiet("row2_row9", 1'b0);
    checkDirect("row4_hits", rangeHits, 0);
    checkDirect("row2_row9_writes", sweepWrites, 160);
    checkDirect("row2_row9_done", doneSeen, 2);

    // Randomized mix of writer traffic and row requests (some out of range).
    clearCounters(0, -1);
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        repeat ($urandom_range(1, 8)) begin
          applyStimulus(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                        7'($urandom_range(0, 127)), 1'b0, 1'b0, 6'd0);
          runCycle("rand_writer");
        end
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                      7'($urandom_range(0, 127)), 1'b0, 1'b1, 6'($urandom_range(0, 63)));
        runCycle("rand_row_req");
        repeat ($urandom_range(5, 100)) begin
          applyStimulus(1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                        7'($urandom_range(0, 127)), 1'b0,
                        1'($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)));
          runCycle("rand_sweep");
        end
      end
    end
    runQuiet("rand_drain", 1'b1);

    // Reset in the middle of a screen sweep.
    clearCounters(0, -1);
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b1, 1'b0, 6'd0);
    runCycle("abort_screen_req");
    applyStimulus(1'b0, 13'd0, 7'd0, 1'b0, 1'b0, 6'd0);
    guard = 0;
    while (mAddr != 1000 && guard < 2000) begin
      runCycle("abort_sweep");
      guard++;
    end
    #1;
    checkOutput("sweep_at_1000");
    resetn = 1'b0;
    #1;
    checkReset("reset_mid_sweep");
    modelReset();
    @(posedge clk);
    #1;
    runCycle("held_in_reset");
    resetn = 1'b1;
    #1;
    checkDirect("ready_after_reset", {29'd0, wrReady, clrBusy, clrDone}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    repeat (5) runCycle("after_abort");
    checkDirect("abort_no_done", doneSeen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
